// File: rtl/itof_share_pkg.sv
// Shared constants and types for the itof sharing controller.
package itof_share_pkg;

  localparam int unsigned ITOF_NSTAGE = 2;
  localparam int unsigned ITOF_NREQ   = 2;
  localparam int unsigned ITOF_TAGW   = 5;

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned idw_of(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ITOF_IDW = idw_of(ITOF_NREQ);

  typedef struct packed {
    logic                v;
    logic [ITOF_IDW-1:0]  id;
    logic [ITOF_TAGW-1:0] tag;
  } inflight_t;

  typedef struct packed {
    logic [ITOF_IDW-1:0]  id;
    logic [ITOF_TAGW-1:0] tag;
    logic [31:0]          data;
  } resp_t;

endpackage

// File: rtl/itof_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from last grant + 1.
module rr_arbiter
  import itof_share_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = idw_of(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] valid,
  input  logic            block,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] last;
  logic           found;

  // Two passes: indices above the last grant first, then wrap to the bottom.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (!block) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (IDW'(i) > last)) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          found     = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (IDW'(i) <= last)) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= IDW'(NREQ - 1);
    end else if (found) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/itof_share_ctrl.sv
// Shares one fixed-latency int-to-float unit between NREQ requesters.
// Optional ITOF_SHARE_PERF_EN adds grant and conflict counters.
module itof_share_ctrl
  import itof_share_pkg::*;
#(
  parameter  int unsigned NREQ   = ITOF_NREQ,
  parameter  int unsigned NSTAGE = ITOF_NSTAGE,
  parameter  int unsigned TAGW   = ITOF_TAGW,
  localparam int unsigned IDW    = idw_of(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic                 flush,
  output logic [31:0]          unit_x,
  input  logic [31:0]          unit_y,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [TAGW-1:0]      resp_tag,
  output logic [31:0]          resp_data
`ifdef ITOF_SHARE_PERF_EN
  ,
  output logic [NREQ*32-1:0]   perf_grant_cnt,
  output logic [31:0]          perf_conflict_cnt
`endif
);

  typedef struct packed {
    logic            v;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
  } slot_t;

  slot_t           shadow [NSTAGE];
  slot_t           head;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            xfer;
  logic [31:0]     data_sel;
  logic [TAGW-1:0] tag_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (req_valid),
    .block     (flush),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign head      = shadow[NSTAGE-1];

  always_comb begin
    data_sel = '0;
    tag_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        data_sel = req_data[i*32 +: 32];
        tag_sel  = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      unit_x <= '0;
    end else if (xfer) begin
      unit_x <= data_sel;
    end
  end

  // Flush only kills valid bits; id/tag are don't-care once invalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NSTAGE; i++) shadow[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NSTAGE; i++) shadow[i].v <= 1'b0;
    end else begin
      shadow[0] <= '{v: xfer, id: grant_idx, tag: tag_sel};
      for (int unsigned i = 1; i < NSTAGE; i++) shadow[i] <= shadow[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_tag   <= '0;
      resp_data  <= '0;
    end else if (!flush && head.v) begin
      resp_valid <= 1'b1;
      resp_id    <= head.id;
      resp_tag   <= head.tag;
      resp_data  <= unit_y;
    end else begin
      resp_valid <= 1'b0;
    end
  end

`ifdef ITOF_SHARE_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_grant_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if (!flush && ($countones(req_valid) >= 2)) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_itof_share_ctrl.sv
// Bench for itof_share_ctrl with a behavioural itof unit and a response-queue model.
module tb_itof_share_ctrl;
  import itof_share_pkg::*;

  localparam int NREQ   = 2;
  localparam int NSTAGE = 2;
  localparam int TAGW   = 5;
  localparam int IDW    = 1;

  logic                 clk  = 1'b0;
  logic                 rstn = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_data = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic                 flush = 1'b0;
  logic [31:0]          unit_x;
  logic [31:0]          unit_y;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [TAGW-1:0]      resp_tag;
  logic [31:0]          resp_data;
`ifdef ITOF_SHARE_PERF_EN
  logic [NREQ*32-1:0]   perf_grant_cnt;
  logic [31:0]          perf_conflict_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  itof_share_ctrl #(.NREQ(NREQ), .NSTAGE(NSTAGE), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .flush      (flush),
    .unit_x     (unit_x),
    .unit_y     (unit_y),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data)
`ifdef ITOF_SHARE_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Signed int32 to IEEE single, round to nearest even.
  function automatic logic [31:0] i2f(logic [31:0] x);
    logic s;
    longint unsigned a, m, rem, half;
    int p, sh;
    if (x == 32'h0) return 32'h0;
    s = x[31];
    a = s ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    p = 0;
    for (int b = 0; b < 33; b++) if (((a >> b) & 64'd1) == 64'd1) p = b;
    if (p <= 23) begin
      m = a << (23 - p);
    end else begin
      sh   = p - 23;
      m    = a >> sh;
      rem  = a & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (m & 64'd1) == 64'd1)) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        p = p + 1;
      end
    end
    return {s, 8'(p + 127), 23'(m)};
  endfunction

  // itof unit: operand register is in the DUT, NSTAGE-1 further stages here.
  logic [31:0] y_pipe;
  always @(posedge clk) y_pipe <= i2f(unit_x);
  assign unit_y = y_pipe;

  function automatic int pick(logic [NREQ-1:0] v, int p, logic fl);
    if (fl) return -1;
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    resp_t r;
    int    due;
  } exp_t;

  exp_t        q[$];
  int          ptr = NREQ - 1;
  logic [31:0] m_ux = '0;
  logic        m_rv = 1'b0;
  resp_t       m_resp = '0;
  int          cyc = 0;
  int          mg;
  resp_t       nr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr    = NREQ - 1;
      m_ux   = '0;
      m_rv   = 1'b0;
      m_resp = '0;
      q.delete();
    end else begin
      cyc++;
      m_rv = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          m_resp = q[0].r;
          m_rv   = 1'b1;
          void'(q.pop_front());
        end
        mg = pick(req_valid, ptr, flush);
        if (mg >= 0) begin
          ptr     = mg;
          m_ux    = req_data[mg*32 +: 32];
          nr.id   = IDW'(mg);
          nr.tag  = req_tag[mg*TAGW +: TAGW];
          nr.data = i2f(req_data[mg*32 +: 32]);
          q.push_back('{r: nr, due: cyc + NSTAGE});
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] er;
    if (cmp_en) begin
      g  = pick(req_valid, ptr, flush);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      check("unit_x", unit_x, m_ux);
      check("resp_valid", 32'(resp_valid), 32'(m_rv));
      check("resp_id", 32'(resp_id), 32'(m_resp.id));
      check("resp_tag", 32'(resp_tag), 32'(m_resp.tag));
      check("resp_data", resp_data, m_resp.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic [31:0] d, logic [TAGW-1:0] t);
    req_valid[i]          = v;
    req_data[i*32 +: 32]  = d;
    req_tag[i*TAGW +: TAGW] = t;
  endtask

`ifdef ITOF_SHARE_PERF_EN
  logic [NREQ*32-1:0] pg0;
  logic [31:0]        pc0;
`endif

  initial begin
    #1 rstn = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_unit_x", unit_x, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);

    // single issue from requester 0
    set_req(0, 1'b1, 32'h0000_0001, 5'd3);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_unit_x", unit_x, 32'h0000_0001);
    check("t1_rv_early0", 32'(resp_valid), 32'h0);
    step();
    @(negedge clk);
    check("t1_rv_early1", 32'(resp_valid), 32'h0);
    step();
    @(negedge clk);
    check("t1_rv", 32'(resp_valid), 32'h1);
    check("t1_data", resp_data, 32'h3F80_0000);
    check("t1_id", 32'(resp_id), 32'h0);
    check("t1_tag", 32'(resp_tag), 32'h3);

    // extreme operands from requester 1, back to back
    set_req(1, 1'b1, 32'hFFFF_FFFF, 5'd7);
    step();
    req_data[32 +: 32] = 32'h8000_0000;
    step();
    req_data[32 +: 32] = 32'h7FFF_FFFF;
    step();
    req_valid = '0;
    @(negedge clk);
    check("t2_data_m1", resp_data, 32'hBF80_0000);
    check("t2_id_a", 32'(resp_id), 32'h1);
    step();
    @(negedge clk);
    check("t2_data_min", resp_data, 32'hCF00_0000);
    check("t2_rv_b", 32'(resp_valid), 32'h1);
    step();
    @(negedge clk);
    check("t2_data_max", resp_data, 32'h4F00_0000);
    check("t2_id_c", 32'(resp_id), 32'h1);

    // contention: both valid for six edges
`ifdef ITOF_SHARE_PERF_EN
    pg0 = perf_grant_cnt;
    pc0 = perf_conflict_cnt;
`endif
    set_req(0, 1'b1, 32'd10, 5'd1);
    set_req(1, 1'b1, 32'd20, 5'd2);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t3_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    req_valid = '0;
`ifdef ITOF_SHARE_PERF_EN
    check("perf_grant0", perf_grant_cnt[31:0] - pg0[31:0], 32'd3);
    check("perf_grant1", perf_grant_cnt[63:32] - pg0[63:32], 32'd3);
    check("perf_conflict", perf_conflict_cnt - pc0, 32'd6);
`endif
    repeat (4) step();

    // flush kills the in-flight op and blocks the simultaneous request
    set_req(0, 1'b1, 32'd5, 5'd4);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'd9, 5'd6);
    flush = 1'b1;
    #1;
    check("t4_ready_flush", 32'(req_ready), 32'h0);
    step();
    flush = 1'b0;
    #1;
    check("t4_ready_after", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t4_no_resp0", 32'(resp_valid), 32'h0);
    step();
    @(negedge clk);
    check("t4_no_resp1", 32'(resp_valid), 32'h0);
    step();
    @(negedge clk);
    check("t4_rv", 32'(resp_valid), 32'h1);
    check("t4_data", resp_data, 32'h4110_0000);
    check("t4_id", 32'(resp_id), 32'h1);

    // reset in the middle of a burst
    set_req(0, 1'b1, 32'd100, 5'd1);
    step();
    req_data[31:0] = 32'd101;
    step();
    rstn = 1'b0;
    req_data[31:0] = 32'd102;
    @(negedge clk);
    check("t5_unit_x", unit_x, 32'h0);
    check("t5_rv", 32'(resp_valid), 32'h0);
    check("t5_id", 32'(resp_id), 32'h0);
    check("t5_tag", 32'(resp_tag), 32'h0);
    check("t5_data", resp_data, 32'h0);
    step();
    rstn = 1'b1;
    set_req(1, 1'b1, 32'd200, 5'd2);
    #1;
    check("t5_first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
